// File: rtl/axi_apb_burst_bridge.sv
// AXI write-burst to APB bridge: per-beat address generation, beat FIFO, APB write
// draining, and a single B response returned once every beat has completed on APB.
module axi_apb_burst_bridge #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int LEN_W      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              awvalid,
    output logic                              awready,
    input  logic [ADDR_W-1:0]                 awaddr,
    input  logic [LEN_W-1:0]                  awlen,
    input  logic [2:0]                        awsize,
    input  logic [1:0]                        awburst,
    input  logic                              wvalid,
    output logic                              wready,
    input  logic [DATA_W-1:0]                 wdata,
    input  logic                              wlast,
    output logic                              bvalid,
    input  logic                              bready,
    output logic [1:0]                        bresp,
    output logic [ADDR_W-1:0]                 paddr,
    output logic                              psel,
    output logic                              penable,
    output logic                              pwrite,
    output logic [DATA_W-1:0]                 pwdata,
    input  logic                              pready,
    input  logic                              pslverr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = $clog2(FIFO_DEPTH+1);
    localparam int ENTRY_W = ADDR_W + DATA_W;

    typedef enum logic [1:0] {AG_IDLE, AG_DATA, AG_DRAIN, AG_RESP} ag_state_t;
    typedef enum logic [1:0] {P_IDLE, P_SETUP, P_ACCESS} p_state_t;
    typedef enum logic [1:0] {M_FIXED, M_INCR, M_WRAP} mode_t;

    ag_state_t ag_state, ag_next;
    p_state_t  p_state, p_next;

    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  len_q;
    logic [2:0]        size_q;
    mode_t             mode_q, aw_mode;
    logic [LEN_W-1:0]  beat_cnt;
    logic              err;
    logic              burst_ok;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level;
    logic               fifo_full, fifo_empty;
    logic               push, pop;

    logic aw_hs, w_hs, last_beat, apb_done;
    logic psel_d, penable_d;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [2:0]        size,
                                                    input logic [LEN_W-1:0]  len,
                                                    input mode_t             mode);
        logic [ADDR_W-1:0] incr, mask, sum;
        incr = ADDR_W'(1) << size;
        sum  = addr + incr;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (mode)
            M_FIXED: next_addr = addr;
            M_WRAP:  next_addr = (addr & ~mask) | (sum & mask);
            default: next_addr = sum;
        endcase
    endfunction

    // WRAP is only legal for 2, 4, 8 or 16 beats
    function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
        logic [LEN_W:0] beats;
        beats = {1'b0, len} + 1'b1;
        wrap_len_ok = (len != '0) && ((beats & (beats - 1'b1)) == '0) &&
                      (beats <= (LEN_W+1)'(16));
    endfunction

    always_comb begin
        aw_mode  = M_INCR;
        burst_ok = 1'b1;
        case (awburst)
            2'b00: aw_mode = M_FIXED;
            2'b01: aw_mode = M_INCR;
            2'b10: begin
                if (wrap_len_ok(awlen)) aw_mode = M_WRAP;
                else                    burst_ok = 1'b0;
            end
            default: burst_ok = 1'b0;
        endcase
    end

    assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (level == '0);
    assign aw_hs      = awvalid && awready;
    assign w_hs       = wvalid && wready;
    assign push       = w_hs;
    assign last_beat  = (beat_cnt == len_q);
    assign apb_done   = (p_state == P_ACCESS) && pready;

    always_comb begin
        ag_next = ag_state;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 2'b00;
        case (ag_state)
            AG_IDLE: if (aw_hs) ag_next = AG_DATA;
            AG_DATA: begin
                wready = !fifo_full;
                if (w_hs && last_beat) ag_next = AG_DRAIN;
            end
            AG_DRAIN: if (fifo_empty && p_state == P_IDLE) ag_next = AG_RESP;
            AG_RESP: begin
                bvalid = 1'b1;
                bresp  = err ? 2'b10 : 2'b00;
                if (bready) ag_next = AG_IDLE;
            end
            default: ag_next = AG_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ag_state <= AG_IDLE;
            awready  <= 1'b0;
            beat_cnt <= '0;
            err      <= 1'b0;
        end else begin
            ag_state <= ag_next;
            awready  <= (ag_next == AG_IDLE);
            if (aw_hs)     beat_cnt <= '0;
            else if (w_hs) beat_cnt <= beat_cnt + 1'b1;
            if (aw_hs)
                err <= !burst_ok;
            else if ((w_hs && (wlast != last_beat)) || (apb_done && pslverr))
                err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs) begin
            cur_addr <= awaddr;
            len_q    <= awlen;
            size_q   <= awsize;
            mode_q   <= aw_mode;
        end else if (w_hs) begin
            cur_addr <= next_addr(cur_addr, size_q, len_q, mode_q);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cur_addr, wdata};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign fifo_level = level;

    // Back-to-back entries skip P_IDLE: psel stays high, penable drops for the new SETUP
    always_comb begin
        p_next    = p_state;
        pop       = 1'b0;
        psel_d    = psel;
        penable_d = penable;
        case (p_state)
            P_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    p_next    = P_SETUP;
                end
            end
            P_SETUP: begin
                penable_d = 1'b1;
                p_next    = P_ACCESS;
            end
            P_ACCESS: begin
                if (pready) begin
                    penable_d = 1'b0;
                    if (!fifo_empty) begin
                        pop    = 1'b1;
                        p_next = P_SETUP;
                    end else begin
                        psel_d = 1'b0;
                        p_next = P_IDLE;
                    end
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                p_next    = P_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_state <= P_IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
        end else begin
            p_state <= p_next;
            psel    <= psel_d;
            penable <= penable_d;
            if (pop) {paddr, pwdata} <= mem[rd_ptr];
        end
    end

    assign pwrite = psel;

endmodule

// File: tb/tb_axi_apb_burst_bridge.sv
// Directed testbench for axi_apb_burst_bridge: burst types, FIFO backpressure,
// error responses and reset during an APB transfer.
module tb_axi_apb_burst_bridge;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 64;
    localparam int LEN_W      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int LVL_W      = $clog2(FIFO_DEPTH+1);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [ADDR_W-1:0] awaddr = '0;
    logic [LEN_W-1:0]  awlen = '0;
    logic [2:0]        awsize = '0;
    logic [1:0]        awburst = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [DATA_W-1:0] wdata = '0;
    logic              wlast = 1'b0;
    logic              bvalid;
    logic              bready = 1'b0;
    logic [1:0]        bresp;
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic              pslverr;
    logic [LVL_W-1:0]  fifo_level;

    axi_apb_burst_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pready(pready), .pslverr(pslverr),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // APB responder controls
    logic              pready_base = 1'b1;
    logic              stall_en = 1'b0;
    logic [ADDR_W-1:0] stall_addr = '0;
    logic              err_en = 1'b0;
    logic [ADDR_W-1:0] err_addr = '0;
    assign pready  = pready_base && !(stall_en && paddr == stall_addr);
    assign pslverr = err_en && psel && penable && (paddr == err_addr);

    // Completed APB transfers, sampled on the falling edge before the completing edge
    logic [ADDR_W-1:0] mon_addr[$];
    logic [DATA_W-1:0] mon_data[$];
    int                mon_cyc[$];
    always @(negedge clk) begin
        if (!reset && psel && penable && pready) begin
            mon_addr.push_back(paddr);
            mon_data.push_back(pwdata);
            mon_cyc.push_back(cyc);
        end
    end

    bit chk_full = 0;
    bit saw_full = 0;

    task automatic mon_clear();
        mon_addr.delete();
        mon_data.delete();
        mon_cyc.delete();
    endtask

    function automatic logic [ADDR_W-1:0] got_addr(input int i);
        return (i < mon_addr.size()) ? mon_addr[i] : '1;
    endfunction

    function automatic logic [DATA_W-1:0] got_data(input int i);
        return (i < mon_data.size()) ? mon_data[i] : '1;
    endfunction

    task automatic send_aw(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                           input logic [2:0] s, input logic [1:0] b);
        bit ok;
        @(posedge clk); #1;
        awvalid = 1'b1; awaddr = a; awlen = l; awsize = s; awburst = b;
        ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (awready) ok = 1;
            @(posedge clk); #1;
        end
        awvalid = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL aw_handshake addr=%h accepted=%0d required=1", a, ok);
        else n_pass++;
    endtask

    task automatic send_w(input logic [LEN_W-1:0] l, input logic [DATA_W-1:0] base,
                          input int wlast_pos);
        bit ok;
        int accepted;
        accepted = 0;
        for (int i = 0; i <= int'(l); i++) begin
            wvalid = 1'b1;
            wdata  = base + DATA_W'(i);
            wlast  = (i == wlast_pos);
            ok = 0;
            for (int n = 0; n < 200 && !ok; n++) begin
                @(negedge clk);
                if (wready) ok = 1;
                else if (chk_full && !saw_full) begin
                    saw_full = 1;
                    n_checks++;
                    if (fifo_level !== LVL_W'(4))
                        $display("FAIL full_level fifo_level=%0d required=4", fifo_level);
                    else n_pass++;
                end
                @(posedge clk); #1;
            end
            if (ok) accepted++;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        n_checks++;
        if (accepted != int'(l) + 1)
            $display("FAIL w_accept beats=%0d required=%0d", accepted, int'(l) + 1);
        else n_pass++;
    endtask

    task automatic get_b(output logic [1:0] r, output int bc);
        bit ok;
        ok = 0; r = 2'b11; bc = 0;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            if (bvalid) begin
                ok = 1; r = bresp; bc = cyc;
                bready = 1'b1;
                @(posedge clk); #1;
                bready = 1'b0;
            end
        end
        n_checks++;
        if (!ok) $display("FAIL bvalid_timeout seen=0 required=1");
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({awready, wready, bvalid, psel, penable, pwrite, bresp} !== 8'h00)
            $display("FAIL reset_ctrl value=%b required=00000000",
                     {awready, wready, bvalid, psel, penable, pwrite, bresp});
        else n_pass++;
        n_checks++;
        if (paddr !== '0 || pwdata !== '0)
            $display("FAIL reset_apb_bus paddr=%h pwdata=%h required=0", paddr, pwdata);
        else n_pass++;
        n_checks++;
        if (fifo_level !== '0) $display("FAIL reset_level level=%0d required=0", fifo_level);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (awready !== 1'b0) $display("FAIL awready_release value=%b required=0", awready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (awready !== 1'b1) $display("FAIL awready_first_edge value=%b required=1", awready);
        else n_pass++;
    endtask

    task automatic test_incr();
        logic [1:0] r;
        int bc;
        logic [ADDR_W-1:0] exp_a;
        mon_clear();
        send_aw(32'h1000, 4'd3, 3'd3, 2'b01);
        send_w(4'd3, 64'hA5A5_0000_0000_0000, 3);
        get_b(r, bc);
        n_checks++;
        if (mon_addr.size() != 4) $display("FAIL incr_count count=%0d required=4", mon_addr.size());
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            exp_a = 32'h1000 + ADDR_W'(8 * i);
            n_checks++;
            if (got_addr(i) !== exp_a || got_data(i) !== 64'hA5A5_0000_0000_0000 + DATA_W'(i))
                $display("FAIL incr_beat%0d paddr=%h pwdata=%h required %h/%h", i, got_addr(i),
                         got_data(i), exp_a, 64'hA5A5_0000_0000_0000 + DATA_W'(i));
            else n_pass++;
        end
        n_checks++;
        if (r !== 2'b00) $display("FAIL incr_bresp bresp=%b required=00", r);
        else n_pass++;
        n_checks++;
        if (mon_cyc.size() == 0 || bc - mon_cyc[mon_cyc.size()-1] != 2)
            $display("FAIL incr_b_latency delta=%0d required=2",
                     mon_cyc.size() == 0 ? -1 : bc - mon_cyc[mon_cyc.size()-1]);
        else n_pass++;
    endtask

    task automatic test_slverr();
        logic [1:0] r;
        int bc;
        mon_clear();
        err_en = 1'b1; err_addr = 32'h3010;
        send_aw(32'h3000, 4'd3, 3'd3, 2'b01);
        send_w(4'd3, 64'h3000, 3);
        get_b(r, bc);
        err_en = 1'b0;
        n_checks++;
        if (mon_addr.size() != 4) $display("FAIL slverr_count count=%0d required=4", mon_addr.size());
        else n_pass++;
        n_checks++;
        if (got_addr(3) !== 32'h3018) $display("FAIL slverr_last_addr paddr=%h required=3018", got_addr(3));
        else n_pass++;
        n_checks++;
        if (r !== 2'b10) $display("FAIL slverr_bresp bresp=%b required=10", r);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [1:0] r;
        int bc;
        logic [ADDR_W-1:0] exp_a [4];
        exp_a[0] = 32'h1018; exp_a[1] = 32'h1000; exp_a[2] = 32'h1008; exp_a[3] = 32'h1010;
        mon_clear();
        send_aw(32'h1018, 4'd3, 3'd3, 2'b10);
        send_w(4'd3, 64'hB000, 3);
        get_b(r, bc);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_addr(i) !== exp_a[i] || got_data(i) !== 64'hB000 + DATA_W'(i))
                $display("FAIL wrap_beat%0d paddr=%h pwdata=%h required %h/%h", i, got_addr(i),
                         got_data(i), exp_a[i], 64'hB000 + DATA_W'(i));
            else n_pass++;
        end
        n_checks++;
        if (r !== 2'b00) $display("FAIL wrap_bresp bresp=%b required=00", r);
        else n_pass++;
    endtask

    task automatic test_fixed_backpressure();
        logic [1:0] r;
        int bc;
        mon_clear();
        pready_base = 1'b0;
        chk_full = 1; saw_full = 0;
        fork
            begin
                send_aw(32'h2000, 4'd7, 3'd3, 2'b00);
                send_w(4'd7, 64'hC000, 7);
            end
            begin
                repeat (14) @(posedge clk);
                #1 pready_base = 1'b1;
            end
        join
        chk_full = 0;
        get_b(r, bc);
        n_checks++;
        if (saw_full != 1) $display("FAIL fixed_wready_drop seen=%0d required=1", saw_full);
        else n_pass++;
        n_checks++;
        if (mon_addr.size() != 8) $display("FAIL fixed_count count=%0d required=8", mon_addr.size());
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (got_addr(i) !== 32'h2000 || got_data(i) !== 64'hC000 + DATA_W'(i))
                $display("FAIL fixed_beat%0d paddr=%h pwdata=%h required 2000/%h", i,
                         got_addr(i), got_data(i), 64'hC000 + DATA_W'(i));
            else n_pass++;
        end
        n_checks++;
        if (r !== 2'b00) $display("FAIL fixed_bresp bresp=%b required=00", r);
        else n_pass++;
    endtask

    task automatic test_wlast_mismatch();
        logic [1:0] r;
        int bc;
        mon_clear();
        send_aw(32'h4000, 4'd3, 3'd3, 2'b01);
        send_w(4'd3, 64'h4000, 1);
        get_b(r, bc);
        n_checks++;
        if (mon_addr.size() != 4) $display("FAIL wlast_count count=%0d required=4", mon_addr.size());
        else n_pass++;
        n_checks++;
        if (r !== 2'b10) $display("FAIL wlast_bresp bresp=%b required=10", r);
        else n_pass++;
    endtask

    task automatic test_reserved_burst();
        logic [1:0] r;
        int bc;
        mon_clear();
        send_aw(32'h5000, 4'd3, 3'd3, 2'b11);
        send_w(4'd3, 64'h5000, 3);
        get_b(r, bc);
        n_checks++;
        if (mon_addr.size() != 4) $display("FAIL rsvd_count count=%0d required=4", mon_addr.size());
        else n_pass++;
        n_checks++;
        if (got_addr(3) !== 32'h5018) $display("FAIL rsvd_incr_addr paddr=%h required=5018", got_addr(3));
        else n_pass++;
        n_checks++;
        if (r !== 2'b10) $display("FAIL rsvd_bresp bresp=%b required=10", r);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [1:0] r;
        int bc;
        bit found;
        mon_clear();
        stall_en = 1'b1; stall_addr = 32'h6008;
        send_aw(32'h6000, 4'd3, 3'd3, 2'b01);
        send_w(4'd3, 64'h6000, 3);
        found = 0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if (psel && penable && paddr == 32'h6008) found = 1;
        end
        n_checks++;
        if (!found) $display("FAIL mid_access_reached seen=0 required=1");
        else n_pass++;
        n_checks++;
        if (fifo_level !== LVL_W'(2)) $display("FAIL mid_level level=%0d required=2", fifo_level);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({psel, penable, bvalid, awready, wready} !== 5'b0)
            $display("FAIL mid_reset_ctrl value=%b required=00000", {psel, penable, bvalid, awready, wready});
        else n_pass++;
        n_checks++;
        if (fifo_level !== '0) $display("FAIL mid_reset_level level=%0d required=0", fifo_level);
        else n_pass++;
        stall_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        mon_clear();
        send_aw(32'h7000, 4'd3, 3'd3, 2'b01);
        send_w(4'd3, 64'h7000, 3);
        get_b(r, bc);
        n_checks++;
        if (mon_addr.size() != 4 || got_addr(0) !== 32'h7000 || got_data(3) !== 64'h7003)
            $display("FAIL post_reset_burst count=%0d addr0=%h data3=%h required 4/7000/7003",
                     mon_addr.size(), got_addr(0), got_data(3));
        else n_pass++;
        n_checks++;
        if (r !== 2'b00) $display("FAIL post_reset_bresp bresp=%b required=00", r);
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_incr();
        test_slverr();
        test_wrap();
        test_fixed_backpressure();
        test_wlast_mismatch();
        test_reserved_burst();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
